// File: rtl/uba_intr_arbiter.sv
// UNIBUS interrupt-acknowledge ("who are you") sequencer for one UBA: picks a
// requesting device/BR for the PI level being acknowledged, grants it, and returns its vector.
module uba_intr_arbiter #(
    parameter int unsigned TIMEOUT = 64,
    parameter bit          RROBIN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wruREQ,
    input  logic [2:0]  wruPI,
    input  logic [2:0]  statPIH,
    input  logic [2:0]  statPIL,
    input  logic [7:4]  devINTR [1:5],
    output logic [7:4]  devACKO [1:5],
    input  logic        devACKR,
    input  logic [15:0] devVECT,
    output logic        wruACK,
    output logic [15:0] wruVECT,
    output logic        wruNXD,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ARB, ACK, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        pi_q, pi_d;
    logic [2:0]        dev_q, dev_d;
    logic [1:0]        brx_q, brx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [19:0]       acko_q, acko_d;
    logic              ack_q, ack_d;
    logic [15:0]       vect_q, vect_d;
    logic              nxd_q, nxd_d;
    logic              busy_q, busy_d;
    logic [3:0][2:0]   ptr_q, ptr_d;

    // req_br[b][d-1]: device d requesting BR(b+4)
    logic [4:0]        req_br [4];
    logic              grp_hi, grp_lo, sel_valid;
    logic [1:0]        sel_brx;
    logic [2:0]        sel_dev, start;
    logic [3:0]        cand;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            for (int d = 1; d <= 5; d++) begin
                req_br[b][d-1] = devINTR[d][b+4];
            end
        end
    end

    // Search starts just after the pointer; fixed priority starts after device 5.
    always_comb begin
        grp_hi  = (pi_q != 3'd0) && (pi_q == statPIH) && (|req_br[3] || |req_br[2]);
        grp_lo  = (pi_q != 3'd0) && (pi_q == statPIL) && (|req_br[1] || |req_br[0]);
        sel_brx = 2'd0;
        if (grp_hi) begin
            sel_brx = (|req_br[3]) ? 2'd3 : 2'd2;
        end else if (grp_lo) begin
            sel_brx = (|req_br[1]) ? 2'd1 : 2'd0;
        end
        start     = RROBIN ? ptr_q[sel_brx] : 3'd5;
        sel_valid = 1'b0;
        sel_dev   = 3'd1;
        cand      = 4'd1;
        for (int k = 1; k <= 5; k++) begin
            cand = {1'b0, start} + 4'(k);
            if (cand > 4'd5) begin
                cand = cand - 4'd5;
            end
            if (!sel_valid && (grp_hi || grp_lo) && req_br[sel_brx][cand - 4'd1]) begin
                sel_valid = 1'b1;
                sel_dev   = cand[2:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pi_d    = pi_q;
        dev_d   = dev_q;
        brx_d   = brx_q;
        cnt_d   = cnt_q;
        acko_d  = acko_q;
        ack_d   = 1'b0;
        vect_d  = vect_q;
        nxd_d   = nxd_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (wruREQ) begin
                    pi_d    = wruPI;
                    state_d = ARB;
                end
            end
            ARB: begin
                if (sel_valid) begin
                    dev_d   = sel_dev;
                    brx_d   = sel_brx;
                    cnt_d   = 8'd0;
                    acko_d  = 20'd1 << {sel_dev - 3'd1, sel_brx};
                    state_d = ACK;
                end else begin
                    ack_d   = 1'b1;
                    nxd_d   = 1'b1;
                    vect_d  = 16'd0;
                    state_d = DONE;
                end
            end
            ACK: begin
                // The acknowledge takes precedence over a coincident terminal count.
                if (devACKR) begin
                    vect_d       = devVECT;
                    nxd_d        = 1'b0;
                    ack_d        = 1'b1;
                    acko_d       = 20'd0;
                    ptr_d[brx_q] = dev_q;
                    state_d      = DONE;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    vect_d  = 16'd0;
                    nxd_d   = 1'b1;
                    ack_d   = 1'b1;
                    acko_d  = 20'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pi_q    <= 3'd0;
            dev_q   <= 3'd1;
            brx_q   <= 2'd0;
            cnt_q   <= 8'd0;
            acko_q  <= 20'd0;
            ack_q   <= 1'b0;
            vect_q  <= 16'd0;
            nxd_q   <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= {4{3'd5}};
        end else begin
            state_q <= state_d;
            pi_q    <= pi_d;
            dev_q   <= dev_d;
            brx_q   <= brx_d;
            cnt_q   <= cnt_d;
            acko_q  <= acko_d;
            ack_q   <= ack_d;
            vect_q  <= vect_d;
            nxd_q   <= nxd_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
        end
    end

    for (genvar d = 1; d <= 5; d++) begin : g_acko
        assign devACKO[d] = acko_q[(d-1)*4 +: 4];
    end

    assign wruACK  = ack_q;
    assign wruVECT = vect_q;
    assign wruNXD  = nxd_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uba_intr_arbiter.sv
// Bench for uba_intr_arbiter: a round-robin and a fixed-priority instance share
// stimulus; a negedge monitor checks grants and WRU results against queued expectations.
module tb_uba_intr_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wruREQ = 1'b0;
  logic [2:0]  wruPI = 3'd0;
  logic [2:0]  statPIH = 3'd0;
  logic [2:0]  statPIL = 3'd0;
  logic [7:4]  devINTR [1:5];
  logic        devACKR = 1'b0;
  logic [15:0] devVECT = 16'd0;

  logic [7:4]  acko_rr [1:5];
  logic        ack_rr, nxd_rr, busy_rr;
  logic [15:0] vect_rr;
  logic [7:4]  acko_fp [1:5];
  logic        ack_fp, nxd_fp, busy_fp;
  logic [15:0] vect_fp;

  uba_intr_arbiter #(.TIMEOUT(TO), .RROBIN(1'b1)) dut (
    .clk(clk), .rst(rst), .wruREQ(wruREQ), .wruPI(wruPI),
    .statPIH(statPIH), .statPIL(statPIL), .devINTR(devINTR), .devACKO(acko_rr),
    .devACKR(devACKR), .devVECT(devVECT), .wruACK(ack_rr), .wruVECT(vect_rr),
    .wruNXD(nxd_rr), .busy(busy_rr)
  );

  uba_intr_arbiter #(.TIMEOUT(TO), .RROBIN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .wruREQ(wruREQ), .wruPI(wruPI),
    .statPIH(statPIH), .statPIL(statPIL), .devINTR(devINTR), .devACKO(acko_fp),
    .devACKR(devACKR), .devVECT(devVECT), .wruACK(ack_fp), .wruVECT(vect_fp),
    .wruNXD(nxd_fp), .busy(busy_fp)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [19:0] enc(input int dev, input int br);
    enc = 20'd1 << ((dev - 1) * 4 + (br - 4));
  endfunction

  // scoreboard: {nxd, vect, ack-phase length, latency}
  logic [32:0] exp_q[$];
  logic [19:0] gnt_rr_q[$];
  logic [19:0] gnt_fp_q[$];

  int          cyc = 0;
  int          req_cyc = 0;
  int          len = 0;
  logic [19:0] prev_g = 20'd0;

  always @(negedge clk) begin
    logic [19:0] g_rr, g_fp, eg;
    logic [32:0] e;
    cyc++;
    for (int d = 1; d <= 5; d++) begin
      g_rr[(d-1)*4 +: 4] = acko_rr[d];
      g_fp[(d-1)*4 +: 4] = acko_fp[d];
    end
    if (!rst) begin
      len    = 0;
      prev_g = 20'd0;
    end else begin
      if (wruREQ) req_cyc = cyc;
      if (g_rr != 20'd0 && prev_g == 20'd0) begin
        if (gnt_rr_q.size() == 0) begin
          check("gnt_unexpected", 64'(g_rr), 64'd0);
        end else begin
          eg = gnt_rr_q.pop_front();
          check("gnt_rr", 64'(g_rr), 64'(eg));
          eg = gnt_fp_q.pop_front();
          check("gnt_fp", 64'(g_fp), 64'(eg));
        end
      end
      if (g_rr != 20'd0) len++;
      prev_g = g_rr;
      if (ack_rr) begin
        if (exp_q.size() == 0) begin
          check("ack_unexpected", 64'(ack_rr), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("nxd", 64'(nxd_rr), 64'(e[32]));
          check("vect", 64'(vect_rr), 64'(e[31:16]));
          check("ack_len", 64'(len), 64'(e[15:8]));
          check("latency", 64'(cyc - req_cyc), 64'(e[7:0]));
          check("fp_ack", 64'(ack_fp), 64'd1);
          check("fp_nxd", 64'(nxd_fp), 64'(e[32]));
          check("fp_vect", 64'(vect_fp), 64'(e[31:16]));
          check("acko_drop", 64'(g_rr), 64'd0);
        end
        len = 0;
      end
    end
  end

  // driver: one WRU cycle; delay = ACK cycles before devACKR (-1 = never), br = 0 for no match
  task automatic wru(input logic [2:0] pi, input int rr_dev, input int fp_dev,
                     input int br, input int delay, input logic [15:0] v);
    logic       nxd;
    logic [15:0] ev;
    int         elen, elat;
    if (br == 0) begin
      nxd = 1'b1; ev = 16'd0; elen = 0; elat = 2;
    end else if (delay < 0 || delay >= TO) begin
      nxd = 1'b1; ev = 16'd0; elen = TO; elat = TO + 2;
    end else begin
      nxd = 1'b0; ev = v; elen = delay + 1; elat = delay + 3;
    end
    exp_q.push_back({nxd, ev, 8'(elen), 8'(elat)});
    if (br != 0) begin
      gnt_rr_q.push_back(enc(rr_dev, br));
      gnt_fp_q.push_back(enc(fp_dev, br));
    end
    @(posedge clk); #1;
    wruREQ = 1'b1; wruPI = pi;
    @(posedge clk); #1;
    wruREQ = 1'b0; wruPI = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    if (br != 0 && delay >= 0 && delay < TO) begin
      for (int i = 0; i < delay; i++) begin
        @(posedge clk); #1;
      end
      devACKR = 1'b1; devVECT = v;
      @(posedge clk); #1;
      devACKR = 1'b0; devVECT = 16'($urandom);
    end
    for (int i = 0; i < 60 && busy_rr; i++) begin
      @(posedge clk); #1;
    end
    check("wru_done", 64'(busy_rr), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic clr_intr();
    for (int d = 1; d <= 5; d++) devINTR[d] = 4'b0000;
  endtask

  initial begin
    logic [19:0] g0;
    int          d;
    clr_intr();
    #12;
    for (int i = 1; i <= 5; i++) g0[(i-1)*4 +: 4] = acko_rr[i];
    check("rst_acko", 64'(g0), 64'd0);
    check("rst_wruack", 64'(ack_rr), 64'd0);
    check("rst_vect", 64'(vect_rr), 64'd0);
    check("rst_nxd", 64'(nxd_rr), 64'd0);
    check("rst_busy", 64'(busy_rr), 64'd0);
    @(negedge clk); rst = 1'b1;

    // round-robin vs fixed priority on BR7 devices 1 and 4
    statPIH = 3'd3; statPIL = 3'd4;
    devINTR[1] = 4'b1000; devINTR[4] = 4'b1000;
    wru(3'd3, 1, 1, 7, 0, 16'($urandom));
    wru(3'd3, 4, 1, 7, 0, 16'($urandom));
    wru(3'd3, 1, 1, 7, 0, 16'($urandom));

    // single device, ack one cycle after grant
    clr_intr(); devINTR[2] = 4'b1000;
    wru(3'd3, 2, 2, 7, 1, 16'o000250);

    // high group wins, then the low group
    clr_intr(); statPIH = 3'd5; statPIL = 3'd5;
    devINTR[3] = 4'b0100; devINTR[5] = 4'b0010;
    wru(3'd5, 3, 3, 6, 0, 16'($urandom));
    devINTR[3] = 4'b0000;
    wru(3'd5, 5, 5, 5, 2, 16'($urandom));

    // no-match cases
    clr_intr(); statPIH = 3'd3; statPIL = 3'd4;
    devINTR[1] = 4'b1001; devINTR[3] = 4'b0010;
    wru(3'd2, 0, 0, 0, 0, 16'd0);
    devINTR[1] = 4'b1000; devINTR[3] = 4'b0000;
    wru(3'd4, 0, 0, 0, 0, 16'd0);
    statPIH = 3'd0; statPIL = 3'd0; devINTR[2] = 4'b0101;
    wru(3'd0, 0, 0, 0, 0, 16'd0);

    // timeout leaves the pointer alone; ack on the terminal count still wins
    clr_intr(); statPIH = 3'd3; statPIL = 3'd4;
    devINTR[1] = 4'b1000; devINTR[4] = 4'b1000;
    wru(3'd3, 4, 1, 7, -1, 16'($urandom));
    wru(3'd3, 4, 1, 7, TO - 1, 16'($urandom));

    // random single requesters
    for (int n = 0; n < 4; n++) begin
      clr_intr();
      d = $urandom_range(1, 5);
      devINTR[d] = 4'b1000;
      wru(3'd3, d, d, 7, $urandom_range(0, 3), 16'($urandom));
    end

    // reset mid-ACK, then device 1 must be searched first again
    clr_intr(); devINTR[1] = 4'b1000;
    wru(3'd3, 1, 1, 7, 0, 16'($urandom));
    devINTR[4] = 4'b1000;
    gnt_rr_q.push_back(enc(4, 7));
    gnt_fp_q.push_back(enc(1, 7));
    @(posedge clk); #1;
    wruREQ = 1'b1; wruPI = 3'd3;
    @(posedge clk); #1;
    wruREQ = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    for (int i = 1; i <= 5; i++) g0[(i-1)*4 +: 4] = acko_rr[i];
    check("async_acko", 64'(g0), 64'd0);
    check("async_busy", 64'(busy_rr), 64'd0);
    check("async_busy_fp", 64'(busy_fp), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    wru(3'd3, 1, 1, 7, 0, 16'($urandom));

    repeat (3) @(posedge clk);
    check("exp_q_left", 64'(exp_q.size()), 64'd0);
    check("gnt_q_left", 64'(gnt_rr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
